// File: rtl/soc_fnd_display.sv
// soc_fnd_display: latch the EKF SOC float, convert it to percent 0..99 and drive two 7-segment digits
// Optional feature: define SOC_DISP_BLANK_LEAD_EN to blank the tens digit when the percent is below 10.
module soc_fnd_display #(
    parameter int FLT_W   = 24,
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 15,
    parameter int PCT_MAX = 99
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [FLT_W-1:0] soc_in,
    input  logic             soc_valid,
    input  logic             hold,
    output logic [6:0]       pct,
    output logic             sat,
    output logic             busy,
    output logic             disp_valid,
    output logic [6:0]       fnd_out_10,
    output logic [6:0]       fnd_out_1
);
    localparam int PW = MAN_W + 8;
    localparam logic [EXP_W-1:0] BIAS = EXP_W'((1 << (EXP_W - 1)) - 1);
    localparam logic [EXP_W-1:0] SHB  = EXP_W'(int'(BIAS) + MAN_W);
    localparam logic [EXP_W-1:0] EMIN = BIAS - EXP_W'(7);
    localparam logic [6:0] PMAX = 7'(PCT_MAX);

    typedef enum logic [2:0] {IDLE, MUL, NORM, BCD, UPD} state_t;

    state_t           state, state_nx;
    logic [FLT_W-1:0] work, pend_val;
    logic             pend;
    logic [PW-1:0]    prod, p_wide;
    logic [EXP_W-1:0] ex;
    logic             sign;
    logic [6:0]       p_norm, p_reg, sh;
    logic             sat_norm, sat_reg;
    logic [7:0]       bcd, bcd_nx;
    logic [3:0]       adj_t, adj_o;
    logic [2:0]       cnt;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7f;
        endcase
    endfunction

    assign sign   = work[FLT_W-1];
    assign ex     = work[FLT_W-2 -: EXP_W];
    assign p_wide = prod >> (SHB - ex);
    assign busy   = (state != IDLE);

    // Percent selection: zero/negative/tiny values give 0, values >= 1.0 saturate, else floor of scaled product
    always_comb begin
        sat_norm = sign || (ex >= BIAS);
        p_norm   = (sign || ex == '0 || ex < EMIN) ? 7'd0 :
                   (ex >= BIAS || p_wide > PW'(PMAX)) ? PMAX : p_wide[6:0];
    end

    // One double-dabble step: add 3 to nibbles >= 5, then shift the next percent bit in
    always_comb begin
        adj_t  = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
        adj_o  = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
        bcd_nx = {adj_t[2:0], adj_o, sh[6]};
    end

    // Next-state logic; a sample arriving during UPD or waiting in pending restarts at MUL
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = soc_valid ? MUL : IDLE;
            MUL:     state_nx = NORM;
            NORM:    state_nx = BCD;
            BCD:     state_nx = (cnt == 3'd6) ? UPD : BCD;
            UPD:     state_nx = (pend || soc_valid) ? MUL : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nx;
    end

    // Datapath, pending slot and display registers; results publish on entry to UPD
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            work       <= '0;
            pend_val   <= '0;
            pend       <= 1'b0;
            prod       <= '0;
            p_reg      <= '0;
            sat_reg    <= 1'b0;
            sh         <= '0;
            bcd        <= '0;
            cnt        <= '0;
            pct        <= '0;
            sat        <= 1'b0;
            disp_valid <= 1'b0;
            fnd_out_10 <= 7'h40;
            fnd_out_1  <= 7'h40;
        end else begin
            disp_valid <= 1'b0;
            if (soc_valid && state != IDLE) begin
                pend_val <= soc_in;
                pend     <= 1'b1;
            end
            case (state)
                IDLE: if (soc_valid) work <= soc_in;
                MUL:  prod <= PW'({1'b1, work[MAN_W-1:0]}) * PW'(100);
                NORM: begin
                    p_reg   <= p_norm;
                    sat_reg <= sat_norm;
                    sh      <= p_norm;
                    bcd     <= '0;
                    cnt     <= '0;
                end
                BCD: begin
                    bcd <= bcd_nx;
                    sh  <= {sh[5:0], 1'b0};
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd6) begin
                        pct        <= p_reg;
                        sat        <= sat_reg;
                        disp_valid <= 1'b1;
                        if (!hold) begin
`ifdef SOC_DISP_BLANK_LEAD_EN
                            fnd_out_10 <= (p_reg < 7'd10) ? 7'h7f : seg7(bcd_nx[7:4]);
`else
                            fnd_out_10 <= seg7(bcd_nx[7:4]);
`endif
                            fnd_out_1  <= seg7(bcd_nx[3:0]);
                        end
                    end
                end
                UPD: begin
                    if (soc_valid) begin
                        work <= soc_in;
                        pend <= 1'b0;
                    end else if (pend) begin
                        work <= pend_val;
                        pend <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
